// File: rtl/miner_core_compress.sv
// miner_core_compress: SHA-256 compression, one round per clock.
// Consumes a 64-word schedule and a chaining value, emits the new hash.
module miner_core_compress (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [0:63][0:31] w,
  input  logic [0:255]     h_in,
  output logic [0:255]     hash,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t      state;
  state_t      state_n;
  logic [5:0]  t;
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [255:0] hs;
  logic        done_q;

  logic [31:0] wt, s0, s1, ch, maj, t1, t2;

  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  // next-state: 64 rounds, then one finalisation cycle
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = ROUND;
      ROUND:   if (t == 6'd63) state_n = FINAL;
      FINAL:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // outputs: busy spans ROUND and FINAL, done follows FINAL
  always_comb begin
    busy = (state != IDLE);
    done = done_q;
  end

  // round function for the current t
  always_comb begin
    wt  = w[t];
    s1  = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
    ch  = (e & f) ^ (~e & g);
    t1  = h + s1 + ch + K[t] + wt;
    s0  = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t2  = s0 + maj;
  end

  // working variables, saved chaining value and hash result
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a    <= '0;
      b    <= '0;
      c    <= '0;
      d    <= '0;
      e    <= '0;
      f    <= '0;
      g    <= '0;
      h    <= '0;
      hs   <= '0;
      t    <= '0;
      hash <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a  <= h_in[0:31];
            b  <= h_in[32:63];
            c  <= h_in[64:95];
            d  <= h_in[96:127];
            e  <= h_in[128:159];
            f  <= h_in[160:191];
            g  <= h_in[192:223];
            h  <= h_in[224:255];
            hs <= h_in;
            t  <= '0;
          end
        end
        ROUND: begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          t <= t + 6'd1;
        end
        FINAL: begin
          hash <= {hs[255:224] + a, hs[223:192] + b,
                   hs[191:160] + c, hs[159:128] + d,
                   hs[127:96]  + e, hs[95:64]   + f,
                   hs[63:32]   + g, hs[31:0]    + h};
        end
        default: ;
      endcase
    end
  end

  // one-cycle completion pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) done_q <= 1'b0;
    else        done_q <= (state == FINAL);
  end

endmodule

// File: tb/tb_miner_core_compress.sv
// tb_miner_core_compress: known vectors plus random chunks
// checked against a plain SHA-256 model.
module tb_miner_core_compress;

  typedef logic [7:0][31:0]  hv_t;
  typedef logic [63:0][31:0] sch_t;
  typedef logic [15:0][31:0] blk_t;

  localparam logic [255:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start;
  logic [0:63][0:31] w;
  logic [0:255]     h_in;
  logic [0:255]     hash;
  logic             done;
  logic             busy;

  int total = 0;
  int bad   = 0;

  hv_t  iv;
  sch_t abc_s;
  sch_t emp_s;

  miner_core_compress dut (
    .clk   (clk),
    .n_rst (n_rst),
    .start (start),
    .w     (w),
    .h_in  (h_in),
    .hash  (hash),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [255:0] got,
    input logic [255:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(
    input logic [31:0] x,
    input int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic sch_t expand(input blk_t m);
    sch_t s;
    logic [31:0] x0, x1;
    for (int i = 0; i < 16; i++) s[i] = m[i];
    for (int i = 16; i < 64; i++) begin
      x0 = rr(s[i-15], 7) ^ rr(s[i-15], 18) ^ (s[i-15] >> 3);
      x1 = rr(s[i-2], 17) ^ rr(s[i-2], 19) ^ (s[i-2] >> 10);
      s[i] = s[i-16] + x0 + s[i-7] + x1;
    end
    return s;
  endfunction

  function automatic logic [255:0] ref_compress(
    input hv_t  hv,
    input sch_t ws
  );
    logic [31:0] v [8];
    logic [31:0] x1, x2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = hv[i];
    for (int i = 0; i < 64; i++) begin
      x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + ws[i];
      x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[i] + v[i];
    return r;
  endfunction

  task automatic set_in(input hv_t hv, input sch_t ws);
    for (int i = 0; i < 8; i++) h_in[i*32 +: 32] = hv[i];
    for (int i = 0; i < 64; i++) w[i] = ws[i];
  endtask

  task automatic junk_h;
    for (int i = 0; i < 8; i++) h_in[i*32 +: 32] = $urandom;
  endtask

  task automatic run_chk(
    input string        tag,
    input hv_t          hv,
    input sch_t         ws,
    input logic [255:0] exp,
    input int           pa,
    input int           pb
  );
    int lat, nd;
    bit early, moved;
    logic [255:0] prev, got;
    set_in(hv, ws);
    prev  = hash;
    got   = '0;
    lat   = -1;
    nd    = 0;
    early = 0;
    moved = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!busy) early = 1;
    junk_h();
    for (int k = 1; k <= 80; k++) begin
      if (k == pa || k == pb) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        nd++;
        if (lat < 0) lat = k;
      end
      if (k <= 64 && !busy) early = 1;
      if (k == 65 && busy) early = 1;
      if (k <= 64 && hash !== prev) moved = 1;
      if (k == 65) got = hash;
    end
    chk({tag, "_hash"}, got, exp);
    chk({tag, "_lat"}, 256'(lat), 256'(65));
    chk({tag, "_ndone"}, 256'(nd), 256'(1));
    chk({tag, "_busy"}, 256'(early), 256'(0));
    chk({tag, "_hold"}, 256'(moved), 256'(0));
  endtask

  initial begin
    blk_t m;
    hv_t  rh;
    sch_t rs;
    logic [255:0] prev;
    int   nd, first, last;
    bit   gap, hbad, idle_bad;

    iv = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
          32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    m = '0;
    m[0] = 32'h61626380;
    m[15] = 32'h00000018;
    abc_s = expand(m);
    m = '0;
    m[0] = 32'h80000000;
    emp_s = expand(m);

    n_rst = 1'b0;
    start = 1'b0;
    w     = '0;
    h_in  = '0;
    #12;
    chk("rst_hash", 256'(hash), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;

    run_chk("abc", iv, abc_s, ABC, 0, 0);
    run_chk("empty", iv, emp_s, EMPTY, 0, 0);
    run_chk("ign", iv, abc_s, ABC, 10, 40);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) rh[i] = $urandom;
      for (int i = 0; i < 64; i++) rs[i] = $urandom;
      run_chk($sformatf("rnd%0d", r), rh, rs,
              ref_compress(rh, rs), 0, 0);
    end

    // back-to-back with start held high
    set_in(iv, abc_s);
    start = 1'b1;
    nd = 0;
    first = -1;
    last = -1;
    gap = 0;
    hbad = 0;
    @(posedge clk); #1;
    junk_h();
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k % 66 == 0) junk_h();
      if (k % 66 == 65) set_in(iv, abc_s);
      if (done) begin
        nd++;
        if (first < 0) first = k;
        if (last >= 0 && k - last != 66) gap = 1;
        last = k;
        if (256'(hash) !== ABC) hbad = 1;
      end
    end
    start = 1'b0;
    chk("b2b_first", 256'(first), 256'(65));
    chk("b2b_count", 256'(nd), 256'(3));
    chk("b2b_gap", 256'(gap), 256'(0));
    chk("b2b_hash", 256'(hbad), 256'(0));
    repeat (70) begin
      @(posedge clk); #1;
    end

    // reset in the middle of a run
    set_in(iv, abc_s);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
    end
    n_rst = 1'b0;
    #1;
    chk("mrst_hash", 256'(hash), 256'(0));
    chk("mrst_busy", 256'(busy), 256'(0));
    chk("mrst_done", 256'(done), 256'(0));
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    nd = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("mrst_nodone", 256'(nd), 256'(0));
    run_chk("mrst_emp", iv, emp_s, EMPTY, 0, 0);

    // idle hold while inputs toggle
    prev = hash;
    idle_bad = 0;
    for (int k = 0; k < 200; k++) begin
      junk_h();
      for (int i = 0; i < 64; i++) w[i] = $urandom;
      @(posedge clk); #1;
      if (256'(hash) !== prev || done || busy) idle_bad = 1;
    end
    chk("idle_hash", 256'(hash), EMPTY);
    chk("idle_hold", 256'(idle_bad), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
